muxn_stream: RTL and testbench

Parametrised N-way stream multiplexer with a registered valid/ready output stage, succeeding the fixed 4:1 combinational datapath mux. It selects one of N WIDTH-bit input channels, either by an explicit select or by arbitration among valid channels, and holds the chosen word in a single-entry output register until the consumer accepts it. It sits between multiple datapath producers (ALU, memory read, immediate, PC-relative) and a single pipelined consumer that can stall.

---
 rtl/muxn_pkg.sv | 28 ++
 rtl/muxn_arbiter.sv | 43 ++++
 rtl/muxn_stream.sv | 102 ++++++++++
 tb/tb_muxn_stream.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/muxn_pkg.sv
// Shared types and helpers for the N-way stream multiplexer.
// Holds output-register state encoding, mode encodings and round-robin wrap helper.
package muxn_pkg;

  typedef enum logic {
    STATE_EMPTY = 1'b0,
    STATE_FULL  = 1'b1
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ARB    = 1'b1;

  // Widest index supported (N up to 16).
  localparam int unsigned MAX_SELW = 4;

  // Index following idx, wrapping to 0 after n-1.
  function automatic logic [MAX_SELW-1:0] rr_next(input logic [MAX_SELW-1:0] idx,
                                                  input int unsigned n);
    logic [MAX_SELW-1:0] res;
    if ((32'(idx) + 32'd1) >= n) begin
      res = '0;
    end else begin
      res = idx + MAX_SELW'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/muxn_arbiter.sv
// Stateless grant logic: direct select (mode 0) or first valid channel at/after ptr (mode 1).
// With ptr held at 0 the arbitrated search degenerates to fixed lowest-index priority.
module muxn_arbiter
  import muxn_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    in_valid,
  input  logic [SELW-1:0] ptr,
  input  logic            mode,
  input  logic [SELW-1:0] sel,
  output logic            grant_valid,
  output logic [SELW-1:0] grant_idx
);

  logic [SELW:0] cand_c;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand_c      = '0;
    if (mode == MODE_DIRECT) begin
      // Out-of-range selects never grant.
      if ((32'(sel) < N) && in_valid[sel]) begin
        grant_valid = 1'b1;
        grant_idx   = sel;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        cand_c = {1'b0, ptr} + (SELW+1)'(i);
        if (32'(cand_c) >= N) begin
          cand_c = cand_c - (SELW+1)'(N);
        end
        if (!grant_valid && in_valid[cand_c[SELW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand_c[SELW-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/muxn_stream.sv
// N-way stream mux with a single-entry registered valid/ready output stage.
// Define MUXN_RR_EN for round-robin arbitration in mode 1; otherwise fixed lowest-index priority.
module muxn_stream
  import muxn_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  output logic                 out_valid,
  input  logic                 out_ready
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [SELW-1:0]   out_src_q, out_src_d;
  logic [SELW-1:0]   ptr_c;
  logic              grant_valid;
  logic [SELW-1:0]   grant_idx;
  logic              can_load_c;
  logic              xfer_c;

  muxn_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arbiter (
    .in_valid    (in_valid),
    .ptr         (ptr_c),
    .mode        (mode),
    .sel         (sel),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

`ifdef MUXN_RR_EN
  logic [SELW-1:0] ptr_q, ptr_d;

  // Pointer advances past the winner only on arbitrated transfers.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer_c && (mode == MODE_ARB)) begin
      ptr_d = SELW'(rr_next(MAX_SELW'(grant_idx), N));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_c = ptr_q;
`else
  assign ptr_c = '0;
`endif

  // Load when empty or draining this cycle; reset suppresses every handshake.
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_src_d  = out_src_q;
    in_ready   = '0;
    can_load_c = (state_q == STATE_EMPTY) || out_ready;
    xfer_c     = !rst && grant_valid && can_load_c;
    if (xfer_c) begin
      in_ready[grant_idx] = 1'b1;
      state_d             = STATE_FULL;
      out_data_d          = in_data[32'(grant_idx)*WIDTH +: WIDTH];
      out_src_d           = grant_idx;
    end else if ((state_q == STATE_FULL) && out_ready) begin
      state_d = STATE_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= STATE_EMPTY;
      out_data_q <= '0;
      out_src_q  <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_src_q  <= out_src_d;
    end
  end

  assign out_valid = (state_q == STATE_FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_muxn_stream.sv
// Scoreboard bench for muxn_stream: driver predicts grants/words, monitor checks consumed words.
// Works with or without MUXN_RR_EN defined.
module tb_muxn_stream;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned SW = 2;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] src;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [W-1:0]    out_data;
  logic [SW-1:0]   out_src;
  logic            out_valid;
  logic            out_ready;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state
  logic m_full = 1'b0;
  int   m_ptr  = 0;

  logic          force_en = 1'b0;
  int            force_ch = 0;
  logic [W-1:0]  force_val = '0;

  muxn_stream #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, then check handshake and advance the model.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic m,
                       input logic [SW-1:0] s, input logic ordy);
    logic [N-1:0] exp_rdy;
    int           best;
    logic         can;
    @(negedge clk);
    rst = r; in_valid = v; mode = m; sel = s; out_ready = ordy;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = W'($urandom);
    if (force_en) in_data[force_ch*W +: W] = force_val;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_full));
    exp_rdy = '0;
    if (r) begin
      sb_q.delete();
      m_full = 1'b0;
      m_ptr  = 0;
    end else begin
      best = -1;
      if (m == 1'b0) begin
        if (int'(s) < N && v[s]) best = int'(s);
      end else begin
        for (int k = m_ptr; k < N; k++) if (v[k] && best < 0) best = k;
        for (int k = 0; k < N; k++) if (v[k] && best < 0) best = k;
      end
      can = !m_full || ordy;
      if (best >= 0 && can) begin
        exp_rdy[best] = 1'b1;
        sb_q.push_back('{data: in_data[best*W +: W], src: SW'(best)});
        m_full = 1'b1;
`ifdef MUXN_RR_EN
        if (m == 1'b1) m_ptr = (best + 1) % N;
`endif
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
    end
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
  endtask

  // Monitor: a word is consumed at the next edge when out_valid && out_ready.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_empty: got word %0h src %0d expected none", out_data, out_src);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", 32'(out_data), 32'(e.data));
        chk("sb_src", 32'(out_src), 32'(e.src));
      end
    end
  end

  initial begin
    int exp_seq[7];
`ifdef MUXN_RR_EN
    exp_seq = '{0, 1, 3, 0, 1, 3, 0};
`else
    exp_seq = '{0, 0, 0, 0, 0, 0, 0};
`endif
    rst = 1'b1; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0; in_data = '0;

    // Reset with all channels valid
    cycle(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0, 2'd0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_src", 32'(out_src), 32'h0);
    cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);

    // Direct select of channel 2
    force_en = 1'b1; force_ch = 2; force_val = 16'hBEEF;
    cycle(1'b0, 4'b1111, 1'b0, 2'd2, 1'b1);
    chk("dir_in_ready", 32'(in_ready), 32'h4);
    force_en = 1'b0;
    cycle(1'b0, 4'b0111, 1'b0, 2'd3, 1'b1);
    chk("dir_data", 32'(out_data), 32'hBEEF);
    chk("dir_src", 32'(out_src), 32'd2);
    chk("dir_nogrant", 32'(in_ready), 32'h0);
    cycle(1'b0, 4'b0111, 1'b0, 2'd3, 1'b1);
    chk("dir_drained", 32'(out_valid), 32'd0);

    // Arbitrated sequence with no bubbles
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 4'b1011, 1'b1, 2'd0, 1'b1);
      if (i > 0) begin
        chk("arb_src", 32'(out_src), 32'(exp_seq[i-1]));
        chk("arb_no_bubble", 32'(out_valid), 32'd1);
      end
    end

    // Two requesters held
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'b1010, 1'b1, 2'd0, 1'b1);
`ifndef MUXN_RR_EN
      if (i > 0) chk("fixed_src", 32'(out_src), 32'd1);
`endif
    end

    // Back-pressure then drain-and-load
    cycle(1'b0, 4'b0001, 1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1111, 1'b1, 2'd0, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      if (sb_q.size() > 0) chk("bp_hold", 32'(out_data), 32'(sb_q[0].data));
      else chk("bp_queue", 32'(sb_q.size()), 32'd1);
    end
    cycle(1'b0, 4'b0100, 1'b0, 2'd2, 1'b1);
    chk("bp_reload_rdy", 32'(in_ready), 32'h4);
    cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    chk("bp_still_valid", 32'(out_valid), 32'd1);
    chk("bp_src", 32'(out_src), 32'd2);

    // Reset while full
    cycle(1'b0, 4'b0010, 1'b1, 2'd0, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    cycle(1'b1, 4'b1111, 1'b1, 2'd0, 1'b0);
    cycle(1'b0, 4'b1111, 1'b1, 2'd0, 1'b0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_grant0", 32'(in_ready), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 59) == 0), N'($urandom), 1'($urandom),
            SW'($urandom), ($urandom_range(0, 3) != 0));
    end

    // Flush
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
